// File: rtl/addr_mode_sequencer_pkg.sv
// Addressing-mode encodings shared by the control unit and the EA sequencer.
package instruction_set;

  typedef enum logic [3:0] {
    AddrModeImpl = 4'h0,
    AddrModeImm  = 4'h1,
    AddrModeZp   = 4'h2,
    AddrModeZpX  = 4'h3,
    AddrModeZpY  = 4'h4,
    AddrModeAbs  = 4'h5,
    AddrModeAbsX = 4'h6,
    AddrModeAbsY = 4'h7,
    AddrModeInd  = 4'h8
  } address_mode_t;

  // Encodings above the last listed mode are unsupported.
  function automatic logic mode_valid(input logic [3:0] m);
    return m <= 4'h8;
  endfunction

endpackage

// File: rtl/addr_mode_sequencer_index_adder.sv
// Low-byte index add; the carry marks a page crossing for indexed modes.
module index_adder #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              carry_out
);

  // Zero-extend by one bit so the carry falls out of the add.
  always_comb begin
    {carry_out, sum} = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/addr_mode_sequencer.sv
// Effective-address sequencer: runs the operand/pointer fetch cycles for each
// addressing mode and hands back a registered EA with a one-cycle done pulse.
import instruction_set::*;

module addr_mode_sequencer #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 16,
  parameter bit IND_PAGE_WRAP = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  address_mode_t       mode,
  input  logic [DATA_W-1:0]   index_val,
  input  logic                write_op,
  input  logic [ADDR_W-1:0]   pc,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                rdy,
  output logic                ready,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                pc_inc,
  output logic                done,
  output logic [ADDR_W-1:0]   ea,
  output logic                page_cross,
  output logic                err
);

  if (ADDR_W != 2 * DATA_W) begin : g_width_check
    $error("addr_mode_sequencer: ADDR_W must equal 2*DATA_W");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_LO, S_FETCH_HI, S_INDEX_ADD,
    S_INDEX_FIX, S_PTR_LO, S_PTR_HI, S_DONE
  } state_t;

  state_t              state_q, state_d;
  address_mode_t       mode_q, mode_d;
  logic [DATA_W-1:0]   idx_q, idx_d, lo_q, lo_d, hi_q, hi_d, ptr_q, ptr_d;
  logic [ADDR_W-1:0]   ea_q, ea_d;
  logic                wr_q, wr_d, pcross_q, pcross_d, err_q, err_d;
  logic [DATA_W-1:0]   sum;
  logic                carry;

  index_adder #(.DATA_W(DATA_W)) u_index_adder (
    .a         (lo_q),
    .b         (idx_q),
    .sum       (sum),
    .carry_out (carry)
  );

  assign ea         = ea_q;
  assign page_cross = pcross_q;
  assign err        = err_q;

  // State and working registers; rdy=0 stalls are folded into the _d logic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mode_q   <= AddrModeImpl;
      idx_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      ptr_q    <= '0;
      ea_q     <= '0;
      wr_q     <= 1'b0;
      pcross_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      ptr_q    <= ptr_d;
      ea_q     <= ea_d;
      wr_q     <= wr_d;
      pcross_q <= pcross_d;
      err_q    <= err_d;
    end
  end

  // Next-state, register updates and per-state bus outputs.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    ptr_d    = ptr_q;
    ea_d     = ea_q;
    pcross_d = pcross_q;
    err_d    = 1'b0;
    ready    = 1'b0;
    pc_inc   = 1'b0;
    done     = 1'b0;
    bus_addr = ea_q;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          mode_d   = mode;
          idx_d    = index_val;
          wr_d     = write_op;
          pcross_d = 1'b0;
          if (!mode_valid(mode)) begin
            err_d = 1'b1;
          end else begin
            case (mode)
              AddrModeImpl: state_d = S_DONE;
              AddrModeImm: begin
                ea_d    = pc;
                state_d = S_DONE;
              end
              default:      state_d = S_FETCH_LO;
            endcase
          end
        end
      end
      S_FETCH_LO: begin
        bus_addr = pc;
        pc_inc   = rdy;
        if (rdy) begin
          lo_d = data_in;
          case (mode_q)
            AddrModeZp: begin
              ea_d    = {{DATA_W{1'b0}}, data_in};
              state_d = S_DONE;
            end
            AddrModeZpX, AddrModeZpY: state_d = S_INDEX_ADD;
            default:                  state_d = S_FETCH_HI;
          endcase
        end
      end
      S_FETCH_HI: begin
        bus_addr = pc;
        pc_inc   = rdy;
        if (rdy) begin
          hi_d = data_in;
          case (mode_q)
            AddrModeAbs: begin
              ea_d    = {data_in, lo_q};
              state_d = S_DONE;
            end
            AddrModeAbsX, AddrModeAbsY: begin
              // Full-width base+index: the low-byte carry ripples into hi.
              ea_d     = {data_in + DATA_W'(carry), sum};
              pcross_d = carry;
              state_d  = (carry || wr_q) ? S_INDEX_FIX : S_DONE;
            end
            default:     state_d = S_PTR_LO;
          endcase
        end
      end
      S_INDEX_ADD: begin
        // Zero-page indexing wraps inside page zero; carry is dropped.
        ea_d    = {{DATA_W{1'b0}}, sum};
        state_d = S_DONE;
      end
      S_INDEX_FIX: begin
        // Dummy read at the un-fixed high byte.
        bus_addr = {hi_q, sum};
        if (rdy) state_d = S_DONE;
      end
      S_PTR_LO: begin
        bus_addr = {hi_q, lo_q};
        if (rdy) begin
          ptr_d   = data_in;
          state_d = S_PTR_HI;
        end
      end
      S_PTR_HI: begin
        if (IND_PAGE_WRAP) bus_addr = {hi_q, lo_q + DATA_W'(1)};
        else               bus_addr = {hi_q, lo_q} + ADDR_W'(1);
        if (rdy) begin
          ea_d    = {data_in, ptr_q};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        pc_inc  = (mode_q == AddrModeImm);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_addr_mode_sequencer.sv
// Randomized bench: two sequencers (page-wrapping and full-increment indirect)
// share stimulus and are scored against an address-level reference model.
import instruction_set::*;

module tb_addr_mode_sequencer;

  logic          clk = 1'b0;
  logic          reset, start, write_op, rdy;
  address_mode_t mode;
  logic [7:0]    index_val, data_in0, data_in1;
  logic [15:0]   pc;
  logic          ready0, pc_inc0, done0, page_cross0, err0;
  logic          ready1, pc_inc1, done1, page_cross1, err1;
  logic [15:0]   bus_addr0, bus_addr1, ea0, ea1;

  logic [7:0]    mem [0:65535];
  logic [15:0]   ba0 [0:63];
  logic [15:0]   ba1 [0:63];
  logic          pi  [0:63];
  int            tests = 0, fails = 0;
  int            mea0 = 0, mea1 = 0;

  always #5 clk = ~clk;

  assign data_in0 = mem[bus_addr0];
  assign data_in1 = mem[bus_addr1];

  addr_mode_sequencer #(.DATA_W(8), .ADDR_W(16), .IND_PAGE_WRAP(1'b1)) dut0 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .index_val(index_val),
    .write_op(write_op), .pc(pc), .data_in(data_in0), .rdy(rdy), .ready(ready0),
    .bus_addr(bus_addr0), .pc_inc(pc_inc0), .done(done0), .ea(ea0),
    .page_cross(page_cross0), .err(err0));

  addr_mode_sequencer #(.DATA_W(8), .ADDR_W(16), .IND_PAGE_WRAP(1'b0)) dut1 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .index_val(index_val),
    .write_op(write_op), .pc(pc), .data_in(data_in1), .rdy(rdy), .ready(ready1),
    .bus_addr(bus_addr1), .pc_inc(pc_inc1), .done(done1), .ea(ea1),
    .page_cross(page_cross1), .err(err1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: what the 6502 addressing rules say the EA, latency and PC
  // advance are, read straight from the memory image.
  task automatic model(input address_mode_t m, input int idx, input bit wr, input int pc0,
                       input bit wrap, input int prev, output int e_ea, output int e_pcx,
                       output int e_lat, output int e_inc, output bit e_err);
    int lo, hi, base, ha;
    lo = mem[pc0]; hi = mem[(pc0 + 1) % 65536]; base = hi * 256 + lo;
    e_ea = prev; e_pcx = 0; e_err = 0; e_lat = 1; e_inc = 0;
    case (m)
      AddrModeImpl: ;
      AddrModeImm:  begin e_ea = pc0; e_inc = 1; end
      AddrModeZp:   begin e_ea = lo; e_lat = 2; e_inc = 1; end
      AddrModeZpX, AddrModeZpY: begin e_ea = (lo + idx) % 256; e_lat = 3; e_inc = 1; end
      AddrModeAbs:  begin e_ea = base; e_lat = 3; e_inc = 2; end
      AddrModeAbsX, AddrModeAbsY: begin
        e_ea = (base + idx) % 65536; e_pcx = (lo + idx > 255) ? 1 : 0;
        e_lat = (e_pcx == 1 || wr) ? 4 : 3; e_inc = 2;
      end
      AddrModeInd: begin
        ha = wrap ? ((base & 16'hFF00) | ((base + 1) & 255)) : (base + 1) % 65536;
        e_ea = mem[ha] * 256 + mem[base]; e_lat = 5; e_inc = 2;
      end
      default: e_err = 1;
    endcase
  endtask

  // stall: 0 = rdy held high, 1 = random rdy, 2 = rdy low for cycles 2..4
  task automatic run_txn(input address_mode_t m, input logic [7:0] idx, input logic wr,
                         input logic [15:0] pc0, input int stall, output int cyc);
    int   e_ea0, e_ea1, e_pcx, e_lat, e_inc, d0, d1, d2, incs;
    bit   e_err, e_err1;
    logic got_done, got_err;
    model(m, idx, wr, pc0, 1'b1, mea0, e_ea0, e_pcx, e_lat, e_inc, e_err);
    model(m, idx, wr, pc0, 1'b0, mea1, e_ea1, d0, d1, d2, e_err1);
    @(negedge clk);
    pc = pc0; rdy = 1'b1;
    #1 chk("ready_idle", ready0, 1'b1);
    mode = m; index_val = idx; write_op = wr; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1; incs = 0; got_done = 1'b0; got_err = 1'b0;
    forever begin
      if (stall == 1)      rdy = ($urandom_range(0, 3) != 0);
      else if (stall == 2) rdy = !(cyc >= 2 && cyc <= 4);
      else                 rdy = 1'b1;
      #1;
      ba0[cyc] = bus_addr0; ba1[cyc] = bus_addr1; pi[cyc] = pc_inc0;
      if (done0)   begin got_done = 1'b1; break; end
      if (err0)    begin got_err = 1'b1; break; end
      if (cyc >= 40) break;
      @(negedge clk);
      if (pi[cyc]) begin pc = pc + 16'd1; incs++; end
      cyc++;
    end
    if (pi[cyc]) incs++;
    chk("done_seen", got_done, !e_err);
    chk("err_seen", got_err, e_err);
    if (stall == 0) chk("latency", cyc, e_lat);
    chk("pc_incs", incs, e_inc);
    chk("ea_wrap", ea0, e_ea0);
    chk("ea_nowrap", ea1, e_ea1);
    if (got_done) begin
      chk("page_cross", page_cross0, e_pcx);
      chk("ready_in_done", ready0, 1'b0);
      chk("done_both", done1, 1'b1);
    end else begin
      chk("no_done_on_err", done0, 1'b0);
    end
    rdy = 1'b1;
    @(negedge clk);
    #1;
    chk("done_pulse", done0, 1'b0);
    chk("err_pulse", err0, 1'b0);
    chk("ea_held", ea0, e_ea0);
    chk("ready_after", ready0, 1'b1);
    mea0 = e_ea0; mea1 = e_ea1;
  endtask

  initial begin
    int cyc;
    address_mode_t rm;
    reset = 1'b0; start = 1'b0; mode = AddrModeImpl; index_val = '0;
    write_op = 1'b0; pc = '0; rdy = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", ready0, 1'b1);
    chk("rst_done", done0, 1'b0);
    chk("rst_ea", ea0, 16'h0000);
    chk("rst_pcx", page_cross0, 1'b0);
    chk("rst_err", err0, 1'b0);
    reset = 1'b1;

    // ABS: two operand fetches at pc, pc+1
    mem[16'h0200] = 8'h34; mem[16'h0201] = 8'h12;
    run_txn(AddrModeAbs, 8'h00, 1'b0, 16'h0200, 0, cyc);
    chk("abs_ba1", ba0[1], 16'h0200);
    chk("abs_ba2", ba0[2], 16'h0201);
    chk("abs_ea", ea0, 16'h1234);

    // ABSX with page cross -> fix cycle and dummy read {hi, lo+idx}
    mem[16'h0300] = 8'hF8; mem[16'h0301] = 8'h12;
    run_txn(AddrModeAbsX, 8'h10, 1'b0, 16'h0300, 0, cyc);
    chk("absx_cross_lat", cyc, 4);
    chk("absx_cross_ea", ea0, 16'h1308);
    chk("absx_dummy_ba", ba0[3], 16'h1208);
    mem[16'h0300] = 8'h20;
    run_txn(AddrModeAbsX, 8'h10, 1'b0, 16'h0300, 0, cyc);
    chk("absx_nocross_lat", cyc, 3);
    chk("absx_nocross_ea", ea0, 16'h1230);
    run_txn(AddrModeAbsY, 8'h10, 1'b1, 16'h0300, 0, cyc);
    chk("absx_write_lat", cyc, 4);

    // ZPX wraps in page zero
    mem[16'h0400] = 8'hF0;
    run_txn(AddrModeZpX, 8'h20, 1'b0, 16'h0400, 0, cyc);
    chk("zpx_ea", ea0, 16'h0010);

    // IND with pointer at page end
    mem[16'h0500] = 8'hFF; mem[16'h0501] = 8'h10;
    mem[16'h10FF] = 8'h78; mem[16'h1000] = 8'h56; mem[16'h1100] = 8'h9A;
    run_txn(AddrModeInd, 8'h00, 1'b0, 16'h0500, 0, cyc);
    chk("ind_ptrhi_wrap", ba0[4], 16'h1000);
    chk("ind_ptrhi_nowrap", ba1[4], 16'h1100);
    chk("ind_ea_wrap", ea0, 16'h5678);
    chk("ind_ea_nowrap", ea1, 16'h9A78);

    // ABS stalled three cycles in FETCH_HI
    run_txn(AddrModeAbs, 8'h00, 1'b0, 16'h0200, 2, cyc);
    chk("stall_lat", cyc, 6);
    for (int c = 2; c <= 4; c++) begin
      chk("stall_ba", ba0[c], 16'h0201);
      chk("stall_pcinc", pi[c], 1'b0);
    end

    // pc wrap at top of memory
    run_txn(AddrModeAbs, 8'h00, 1'b0, 16'hFFFF, 0, cyc);

    // Reset during PTR_LO aborts the sequence
    @(negedge clk);
    mode = AddrModeInd; start = 1'b1; rdy = 1'b1; pc = 16'h0500;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_ready", ready0, 1'b1);
    chk("abort_done", done0, 1'b0);
    chk("abort_ea", ea0, 16'h0000);
    mea0 = 0; mea1 = 0;
    run_txn(address_mode_t'(4'hB), 8'h00, 1'b0, 16'h0600, 0, cyc);

    // Random traffic, including unsupported encodings and random stalls
    for (int n = 0; n < 200; n++) begin
      rm = address_mode_t'(($urandom_range(0, 9) == 9) ? $urandom_range(9, 15)
                                                       : $urandom_range(0, 8));
      run_txn(rm, 8'($urandom), 1'($urandom), 16'($urandom), $urandom_range(0, 1), cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
